register_file: RTL

REGISTER_FILE -- requirements
Module: register_file

---
 rtl/register_file.sv | 60 ++++++
 1 files changed

// File: rtl/register_file.sv
// Integer register file: 2**ADDR_WIDTH x DATA_WIDTH, x0 hardwired to zero, 2R/1W.
// Define REGFILE_WRITE_BYPASS_EN to forward same-cycle write data onto the read ports.
module register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] rs1_addr,
    input  logic [ADDR_WIDTH-1:0] rs2_addr,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  reg_write,
    output logic [DATA_WIDTH-1:0] rs1_data,
    output logic [DATA_WIDTH-1:0] rs2_data
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic                  wr_en;

    assign wr_en = reg_write && (rd_addr != '0);

    // Entry 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[rd_addr] <= rd_data;
        end
    end

    always_comb begin
        rs1_data = regs[rs1_addr];
        if (!rst_n || rs1_addr == '0) begin
            rs1_data = '0;
        end
`ifdef REGFILE_WRITE_BYPASS_EN
        else if (wr_en && rs1_addr == rd_addr) begin
            rs1_data = rd_data;
        end
`endif
    end

    always_comb begin
        rs2_data = regs[rs2_addr];
        if (!rst_n || rs2_addr == '0) begin
            rs2_data = '0;
        end
`ifdef REGFILE_WRITE_BYPASS_EN
        else if (wr_en && rs2_addr == rd_addr) begin
            rs2_data = rd_data;
        end
`endif
    end

endmodule
